// File: rtl/keynsham_bus_fabric.sv
// keynsham_bus_fabric: single-master data-bus decoder and response mux
// with default-slave errors, WAIT timeout and first-fault capture.
module keynsham_bus_fabric #(
  parameter int nr_slaves = 8,
  parameter logic [32*nr_slaves-1:0] slave_bases = '0,
  parameter logic [32*nr_slaves-1:0] slave_sizes = '0,
  parameter logic [15:0] timeout_cycles = 16'd255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m_access,
  input  logic [29:0]             m_addr,
  input  logic                    m_wr_en,
  input  logic [3:0]              m_bytesel,
  input  logic [31:0]             m_wr_val,
  output logic [31:0]             m_data,
  output logic                    m_ack,
  output logic                    m_error,
  output logic [nr_slaves-1:0]    s_cs,
  output logic [nr_slaves-1:0]    s_access,
  output logic [29:0]             s_addr,
  output logic                    s_wr_en,
  output logic [3:0]              s_bytesel,
  output logic [31:0]             s_wr_val,
  input  logic [32*nr_slaves-1:0] s_data,
  input  logic [nr_slaves-1:0]    s_ack,
  input  logic [nr_slaves-1:0]    s_error,
  output logic                    fault_valid,
  output logic                    fault_timeout,
  output logic                    fault_overrun,
  output logic [29:0]             fault_addr,
  input  logic                    fault_clear
);

  localparam int SW = (nr_slaves > 1) ? $clog2(nr_slaves) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, UNMAPPED} state_t;

  state_t        state;
  logic [SW-1:0] sel;
  logic [SW-1:0] hit_idx;
  logic          hit;
  logic [29:0]   lat_addr;
  logic [15:0]   cnt;
  logic [31:0]   rdata [nr_slaves];
  logic          fv, ft, fo;
  logic [29:0]   fa;
  logic          wait_st, sel_ack, tmo, unm, fault_ev;

  // Descending scan so the lowest matching index is the one kept.
  always_comb begin
    s_cs    = '0;
    hit_idx = '0;
    hit     = 1'b0;
    for (int i = nr_slaves - 1; i >= 0; i--) begin
      if (slave_sizes[32*i +: 32] != 32'd0 &&
          (({m_addr, 2'b00} & ~(slave_sizes[32*i +: 32] - 32'd1))
           == slave_bases[32*i +: 32])) begin
        s_cs     = '0;
        s_cs[i]  = 1'b1;
        hit_idx  = SW'(i);
        hit      = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < nr_slaves; i++) begin
      rdata[i] = s_data[32*i +: 32];
    end
  end

  assign s_addr    = m_addr;
  assign s_wr_en   = m_wr_en;
  assign s_bytesel = m_bytesel;
  assign s_wr_val  = m_wr_val;
  assign s_access  = (rst_n && state == IDLE && m_access) ? s_cs : '0;

  assign wait_st  = rst_n && state == WAIT;
  assign sel_ack  = wait_st && s_ack[sel];
  // A slave ack in the deadline cycle beats the timeout.
  assign tmo      = wait_st && !s_ack[sel] && timeout_cycles != 16'd0 &&
                    cnt == timeout_cycles - 16'd1;
  assign unm      = rst_n && state == UNMAPPED;
  assign fault_ev = unm || tmo || (sel_ack && s_error[sel]);

  assign m_ack   = sel_ack || tmo || unm;
  assign m_error = (sel_ack && s_error[sel]) || tmo || unm;
  assign m_data  = (sel_ack && !m_wr_en) ? rdata[sel] : 32'd0;

  assign fault_valid   = rst_n && fv;
  assign fault_timeout = rst_n && ft;
  assign fault_overrun = rst_n && fo;
  assign fault_addr    = rst_n ? fa : 30'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      lat_addr <= '0;
      cnt      <= '0;
      fv       <= 1'b0;
      ft       <= 1'b0;
      fo       <= 1'b0;
      fa       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m_access) begin
            lat_addr <= m_addr;
            if (hit) begin
              sel   <= hit_idx;
              cnt   <= '0;
              state <= WAIT;
            end else begin
              state <= UNMAPPED;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (m_ack) state <= IDLE;
        end
        UNMAPPED: state <= IDLE;
        default:  state <= IDLE;
      endcase

      if (fault_clear) begin
        fv <= fault_ev;
        ft <= tmo;
        fo <= 1'b0;
        fa <= fault_ev ? lat_addr : 30'd0;
      end else if (fault_ev) begin
        if (!fv) begin
          fv <= 1'b1;
          ft <= tmo;
          fa <= lat_addr;
        end else begin
          fo <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keynsham_bus_fabric.sv
// Scoreboard bench for keynsham_bus_fabric: directed accesses push
// expected acks; a negedge monitor pops and compares them.
module tb_keynsham_bus_fabric;

  localparam int N = 4;
  localparam logic [32*N-1:0] BASES =
    {32'h2000_0000, 32'h2000_0000, 32'h4000_0000, 32'h1000_0000};
  localparam logic [32*N-1:0] SIZES =
    {32'h0000_0100, 32'h0000_1000, 32'h0001_0000, 32'h0000_0100};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_access = 1'b0;
  logic [29:0]   m_addr = '0;
  logic          m_wr_en = 1'b0;
  logic [3:0]    m_bytesel = '0;
  logic [31:0]   m_wr_val = '0;
  logic [31:0]   m_data;
  logic          m_ack, m_error;
  logic [N-1:0]  s_cs, s_access;
  logic [29:0]   s_addr;
  logic          s_wr_en;
  logic [3:0]    s_bytesel;
  logic [31:0]   s_wr_val;
  logic [32*N-1:0] s_data = '0;
  logic [N-1:0]  s_ack = '0;
  logic [N-1:0]  s_error = '0;
  logic          fault_valid, fault_timeout, fault_overrun;
  logic [29:0]   fault_addr;
  logic          fault_clear = 1'b0;

  keynsham_bus_fabric #(
    .nr_slaves(N),
    .slave_bases(BASES),
    .slave_sizes(SIZES),
    .timeout_cycles(16'd8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_access(m_access), .m_addr(m_addr), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_wr_val(m_wr_val),
    .m_data(m_data), .m_ack(m_ack), .m_error(m_error),
    .s_cs(s_cs), .s_access(s_access), .s_addr(s_addr),
    .s_wr_en(s_wr_en), .s_bytesel(s_bytesel), .s_wr_val(s_wr_val),
    .s_data(s_data), .s_ack(s_ack), .s_error(s_error),
    .fault_valid(fault_valid), .fault_timeout(fault_timeout),
    .fault_overrun(fault_overrun), .fault_addr(fault_addr),
    .fault_clear(fault_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_ack === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("ack_cycle", 32'(cyc), 32'(mon_e.c));
        check("ack_error", 32'(m_error), 32'(mon_e.err));
        check("ack_data", m_data, mon_e.data);
      end
    end
  end

  task automatic fchk(input logic v, input logic t, input logic o,
                      input logic [29:0] a);
    check("fault_valid", 32'(fault_valid), 32'(v));
    check("fault_timeout", 32'(fault_timeout), 32'(t));
    check("fault_overrun", 32'(fault_overrun), 32'(o));
    check("fault_addr", 32'(fault_addr), 32'(a));
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 fault_clear = 1'b1;
    @(posedge clk); #1 fault_clear = 1'b0;
  endtask

  // One master access; the selected slave acks in cycle dly (-1: never).
  // A selected-slave ack in cycle 0 and a non-selected error ack in
  // cycle 1 are always injected and must be ignored.
  task automatic run(input logic [29:0] addr, input logic wr,
                     input int idx, input int dly,
                     input logic [31:0] rd, input logic serr,
                     input logic [N-1:0] exp_acc, input int lat,
                     input logic eerr, input logic [31:0] edata,
                     input int clr_at, input int rst_at,
                     input int viol_at);
    int   c0;
    int   oth;
    exp_t e;
    oth = (idx + 1) % N;
    @(posedge clk); #1;
    m_access  = 1'b1;
    m_addr    = addr;
    m_wr_en   = wr;
    m_bytesel = 4'hf;
    m_wr_val  = 32'h0bad_f00d ^ {2'b00, addr};
    s_ack[idx]   = 1'b1;
    s_error[idx] = 1'b1;
    c0 = cyc;
    if (lat >= 0) begin
      e.c = c0 + lat;
      e.err = eerr;
      e.data = edata;
      q.push_back(e);
    end
    #1 check("s_access", 32'(s_access), 32'(exp_acc));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      m_access    = (k == viol_at);
      s_ack       = '0;
      s_error     = '0;
      fault_clear = (k == clr_at);
      rst_n       = (k != rst_at);
      if (k == 1 && dly != 1) begin
        s_ack[oth] = 1'b1;
        s_error[oth] = 1'b1;
        s_data[32*oth +: 32] = 32'hffff_ffff;
      end
      if (k == dly) begin
        s_ack[idx] = 1'b1;
        s_error[idx] = serr;
        s_data[32*idx +: 32] = rd;
      end
      if (k == viol_at) begin
        #1 check("viol_no_access", 32'(s_access), 32'd0);
      end
    end
    check("ack_seen", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    m_addr = 30'h0800_0004;
    m_access = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_s_access", 32'(s_access), 32'd0);
    check("rst_s_cs", 32'(s_cs), 32'h4);
    fchk(1'b0, 1'b0, 1'b0, 30'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_access = 1'b0;

    run(30'h0800_0004, 1'b0, 2, 3, 32'hDEAD_BEEF, 1'b0, 4'b0100,
        3, 1'b0, 32'hDEAD_BEEF, -1, -1, -1);
    fchk(1'b0, 1'b0, 1'b0, 30'd0);

    run(30'h0400_0001, 1'b1, 0, 1, 32'h1234_5678, 1'b0, 4'b0001,
        1, 1'b0, 32'd0, -1, -1, -1);
    fchk(1'b0, 1'b0, 1'b0, 30'd0);

    run(30'h1000_0005, 1'b0, 1, 2, 32'h0000_0055, 1'b1, 4'b0010,
        2, 1'b1, 32'h0000_0055, -1, -1, -1);
    fchk(1'b1, 1'b0, 1'b0, 30'h1000_0005);
    pulse_clear();
    fchk(1'b0, 1'b0, 1'b0, 30'd0);

    run(30'h2400_0000, 1'b0, 0, -1, 32'd0, 1'b0, 4'b0000,
        1, 1'b1, 32'd0, -1, -1, -1);
    fchk(1'b1, 1'b0, 1'b0, 30'h2400_0000);
    run(30'h2400_0004, 1'b0, 0, -1, 32'd0, 1'b0, 4'b0000,
        1, 1'b1, 32'd0, -1, -1, -1);
    fchk(1'b1, 1'b0, 1'b1, 30'h2400_0000);
    pulse_clear();
    fchk(1'b0, 1'b0, 1'b0, 30'd0);

    run(30'h2400_0100, 1'b0, 0, -1, 32'd0, 1'b0, 4'b0000,
        1, 1'b1, 32'd0, -1, -1, -1);
    fchk(1'b1, 1'b0, 1'b0, 30'h2400_0100);
    run(30'h2400_0200, 1'b0, 0, -1, 32'd0, 1'b0, 4'b0000,
        1, 1'b1, 32'd0, 1, -1, -1);
    fchk(1'b1, 1'b0, 1'b0, 30'h2400_0200);
    pulse_clear();

    run(30'h0800_0008, 1'b0, 2, 12, 32'h1111_1111, 1'b0, 4'b0100,
        8, 1'b1, 32'd0, -1, -1, -1);
    fchk(1'b1, 1'b1, 1'b0, 30'h0800_0008);
    pulse_clear();

    run(30'h0800_000C, 1'b0, 2, 8, 32'hCAFE_0001, 1'b0, 4'b0100,
        8, 1'b0, 32'hCAFE_0001, -1, -1, -1);
    fchk(1'b0, 1'b0, 1'b0, 30'd0);

    run(30'h0800_0010, 1'b0, 2, 1, 32'hA5A5_A5A5, 1'b0, 4'b0100,
        1, 1'b0, 32'hA5A5_A5A5, -1, -1, -1);

    run(30'h0400_0002, 1'b0, 0, 3, 32'h0000_0077, 1'b0, 4'b0001,
        3, 1'b0, 32'h0000_0077, -1, -1, 1);

    run(30'h0800_0020, 1'b0, 2, 4, 32'h0000_0099, 1'b0, 4'b0100,
        -1, 1'b0, 32'd0, -1, 2, -1);
    fchk(1'b0, 1'b0, 1'b0, 30'd0);
    run(30'h0800_0024, 1'b0, 2, 2, 32'h5EED_0002, 1'b0, 4'b0100,
        2, 1'b0, 32'h5EED_0002, -1, -1, -1);
    fchk(1'b0, 1'b0, 1'b0, 30'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
